tau_toggle_pipe: RTL and testbench
==================================

# tau_toggle_pipe

Parametrised successor of the single-bit NAND/NOR feedback-flop timing cell. The block provides WIDTH independent lanes. Each lane has a feedback register whose next state is selected by a run-time mode, followed by a configurable output register pipeline and a saturating activity counter. It sits in the timing-benchmark netlist family as a scalable sequential load, so STA runs can be exercised across widths, depths and either clock edge.

## Interface
- WIDTH, 8, lanes per vector (1..64)
- STAGES, 1, output pipeline registers after the core register (0..7)
- NEGEDGE, 1, 1 = all flops on the falling edge of tau2015_clk; 0 = rising edge
- CNT_W, 8, width of toggle_cnt
- tau2015_clk  in  1  sole clock
- tau2015_rst  in  1  reset, asynchronous, active-high
- inp1  in  WIDTH  operand A per lane
- inp2  in  WIDTH  operand B per lane
- in_valid  in  1  core register may update this edge
- en  in  1  global enable, ANDed with in_valid
- mode  in  2  next-state function (see Operation)
- out  out  WIDTH  pipelined core state
- out_valid  out  1  out carries a value produced by an accepted update
- toggle_cnt  out  CNT_W  count of accepted updates that changed at least one bit of the core register, saturating

## Operation
- Core register q[WIDTH]. An update is accepted when in_valid & en is 1 at the active edge.
- Next-state function per lane i, by mode:
  - MODE_AND (0): q' = inp1 & inp2 & ~q (legacy cell behaviour)
  - MODE_OR (1): q' = (inp1 | inp2) & ~q
  - MODE_HOLD (2): q' = q
  - MODE_LOAD (3): q' = inp1
- If the update is not accepted, q holds regardless of mode.
- Valid tracking: v0 is registered alongside q and takes the value in_valid & en every edge.
- Pipeline: stage k registers stage k-1 data and valid every active edge, with no stall. out and out_valid are the last stage.
- STAGES=0: out = q and out_valid = v0, both purely combinational from the core flops.
- Activity counter: toggle_cnt increments by 1 on each accepted update where q' != q. It saturates at 2^CNT_W-1 and never wraps.
- Accepted updates with q' == q (including every HOLD) do not count.

## Timing
- Reset asserted: q, all stage registers, out, out_valid and toggle_cnt are 0 immediately, without waiting for a clock edge.
- Reset deasserted: first possible update is the next active edge.
- Reset mid-stream clears all in-flight pipeline data. No stale out_valid is permitted.
- Active edge is the falling edge when NEGEDGE=1 and the rising edge otherwise. No logic uses both edges.
- Latency: an update accepted at active edge n appears on out and out_valid after edge n+STAGES, i.e. STAGES edges after the core update.
- Throughput: one update per edge.
- Simultaneous events:
  - A mode change takes effect on the same edge it is sampled.
  - A counter increment at saturation leaves the value unchanged.
  - in_valid=1 with en=0 is not an update and gives v0=0.

## Structure
- Package tau_toggle_pkg holds:
  - mode_e enum: MODE_AND=0, MODE_OR=1, MODE_HOLD=2, MODE_LOAD=3
  - localparam MAX_STAGES=7
- Sub-module tau_pipe_stage: one WIDTH+1-bit register (data plus valid) with async reset and NEGEDGE parameter. It is instantiated STAGES times via a generate loop.
- The core next-state logic and the counter stay in the top module.

## Test plan
- Reset: assert tau2015_rst between edges with q=8'hFF -> out=0, out_valid=0, toggle_cnt=0 immediately. Then with STAGES=2, accept one update and confirm out_valid first rises exactly 2 edges after the update.
- Legacy AND mode: WIDTH=8, inp1=8'hF0, inp2=8'hFF, in_valid=en=1, three edges -> q goes 8'hF0, 8'h00, 8'hF0; out follows STAGES edges later; toggle_cnt=3.
- OR and LOAD:
  - LOAD inp1=8'h5A -> q=8'h5A.
  - Then OR with inp1=8'h0F, inp2=8'h00 -> q = 8'h0F & ~8'h5A = 8'h05.
  - toggle_cnt=2.
- Hold and enable gating:
  - MODE_HOLD for 4 edges -> q unchanged, toggle_cnt unchanged, out_valid=1.
  - en=0 with in_valid=1 -> q holds and out_valid=0 after STAGES edges.
- Saturation: CNT_W=3, 10 toggling updates -> toggle_cnt stops at 7.
- Edge and depth sweep:
  - NEGEDGE=0/1 x STAGES=0/3: check data changes only on the selected edge.
  - STAGES=0: out equals q combinationally.

Source files
------------

// File: rtl/tau_toggle_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tau_toggle_pkg : shared mode encoding and limits for tau_toggle_pipe
// Revision 1.0
// ---------------------------------------------------------------------------
package tau_toggle_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_HOLD = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  localparam int MAX_STAGES = 7;

endpackage
`default_nettype wire

// File: rtl/tau_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tau_pipe_stage : one data+valid register on the selected clock edge
// Revision 1.0
// ---------------------------------------------------------------------------
module tau_pipe_stage #(
  parameter int WIDTH   = 8,
  parameter int NEGEDGE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  generate
    if (NEGEDGE != 0) begin : g_neg
      always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_i;
          valid_q <= valid_i;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_i;
          valid_q <= valid_i;
        end
      end
    end
  endgenerate

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/tau_toggle_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tau_toggle_pipe : WIDTH-lane mode-selected feedback register, output
//                   pipeline and saturating change counter
// Revision 1.0
// ---------------------------------------------------------------------------
module tau_toggle_pipe
  import tau_toggle_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 1,
  parameter int NEGEDGE = 1,
  parameter int CNT_W   = 8
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             in_valid,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             v0_q, v0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept = in_valid & en;
    q_d    = q_q;
    if (accept) begin
      case (mode_e'(mode))
        MODE_AND:  q_d = inp1 & inp2 & ~q_q;
        MODE_OR:   q_d = (inp1 | inp2) & ~q_q;
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = inp1;
        default:   q_d = q_q;
      endcase
    end
    v0_d  = accept;
    cnt_d = cnt_q;
    // Only accepted updates that actually change state count; stick at all-ones.
    if (accept && (q_d != q_q) && !(&cnt_q)) begin
      cnt_d = cnt_q + c_cnt_one;
    end
  end

  generate
    if (NEGEDGE != 0) begin : g_core_neg
      always_ff @(negedge tau2015_clk or posedge tau2015_rst) begin
        if (tau2015_rst) begin
          q_q   <= '0;
          v0_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          q_q   <= q_d;
          v0_q  <= v0_d;
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_core_pos
      always_ff @(posedge tau2015_clk or posedge tau2015_rst) begin
        if (tau2015_rst) begin
          q_q   <= '0;
          v0_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          q_q   <= q_d;
          v0_q  <= v0_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Element 0 is the core register itself, so STAGES=0 is a pure wire-through.
  logic [WIDTH-1:0] pipe_data  [0:STAGES];
  logic             pipe_valid [0:STAGES];

  assign pipe_data[0]  = q_q;
  assign pipe_valid[0] = v0_q;

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      tau_pipe_stage #(
        .WIDTH   (WIDTH),
        .NEGEDGE (NEGEDGE)
      ) u_stage (
        .clk_i   (tau2015_clk),
        .rst_i   (tau2015_rst),
        .data_i  (pipe_data[k-1]),
        .valid_i (pipe_valid[k-1]),
        .data_o  (pipe_data[k]),
        .valid_o (pipe_valid[k])
      );
    end
  endgenerate

  assign out        = pipe_data[STAGES];
  assign out_valid  = pipe_valid[STAGES];
  assign toggle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tau_toggle_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tau_toggle_pipe : scoreboard bench over three parameter sets
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_tau_toggle_pipe;
  import tau_toggle_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inp1 = '0, inp2 = '0;
  logic       in_valid = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [7:0] a_out, b_out, c_out;
  logic       a_ov, b_ov, c_ov;
  logic [7:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;

  int tests = 0;
  int fails = 0;

  logic [8:0] qa[$];
  logic [8:0] qc[$];
  logic [7:0] mq;
  logic       mv;
  logic [7:0] cnt8;
  logic [2:0] cnt3;

  always #5 clk = ~clk;

  // A: falling edge, 2 stages. B: rising edge, no stages, 3-bit counter. C: rising edge, 3 stages.
  tau_toggle_pipe #(.WIDTH(8), .STAGES(2), .NEGEDGE(1), .CNT_W(8)) u_a (
    .tau2015_clk(clk), .tau2015_rst(rst), .inp1(inp1), .inp2(inp2),
    .in_valid(in_valid), .en(en), .mode(mode),
    .out(a_out), .out_valid(a_ov), .toggle_cnt(a_cnt));

  tau_toggle_pipe #(.WIDTH(8), .STAGES(0), .NEGEDGE(0), .CNT_W(3)) u_b (
    .tau2015_clk(clk), .tau2015_rst(rst), .inp1(inp1), .inp2(inp2),
    .in_valid(in_valid), .en(en), .mode(mode),
    .out(b_out), .out_valid(b_ov), .toggle_cnt(b_cnt));

  tau_toggle_pipe #(.WIDTH(8), .STAGES(3), .NEGEDGE(0), .CNT_W(8)) u_c (
    .tau2015_clk(clk), .tau2015_rst(rst), .inp1(inp1), .inp2(inp2),
    .in_valid(in_valid), .en(en), .mode(mode),
    .out(c_out), .out_valid(c_ov), .toggle_cnt(c_cnt));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq = '0; mv = 1'b0; cnt8 = '0; cnt3 = '0;
    qa.delete(); qc.delete();
    repeat (2) qa.push_back(9'h0);
    repeat (3) qc.push_back(9'h0);
  endtask

  // Entered just after a falling edge; both clock domains see the same inputs once.
  task automatic step(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic iv, input logic e);
    logic [7:0] nq;
    logic       acc;
    logic [8:0] exp_v, a_prev, b_prev, c_prev;
    mode = m; inp1 = a; inp2 = b; in_valid = iv; en = e;
    acc = iv & e;
    case (m)
      2'd0:    nq = a & b & ~mq;
      2'd1:    nq = (a | b) & ~mq;
      2'd2:    nq = mq;
      default: nq = a;
    endcase
    if (!acc) nq = mq;
    if (acc && nq != mq) begin
      if (cnt8 != 8'hFF) cnt8 = cnt8 + 8'd1;
      if (cnt3 != 3'd7)  cnt3 = cnt3 + 3'd1;
    end
    mq = nq; mv = acc;
    qa.push_back({mv, mq});
    qc.push_back({mv, mq});
    a_prev = {a_ov, a_out};

    @(posedge clk); #1;
    chk("B_out", {7'd0, b_ov, b_out}, {7'd0, mv, mq});
    chk("B_cnt", {13'd0, b_cnt}, {13'd0, cnt3});
    if (qc.size() > 3) begin
      exp_v = qc.pop_front();
      chk("C_out", {7'd0, c_ov, c_out}, {7'd0, exp_v});
    end
    chk("C_cnt", {8'd0, c_cnt}, {8'd0, cnt8});
    chk("A_hold_on_rise", {7'd0, a_ov, a_out}, {7'd0, a_prev});
    b_prev = {b_ov, b_out};
    c_prev = {c_ov, c_out};

    @(negedge clk); #1;
    if (qa.size() > 2) begin
      exp_v = qa.pop_front();
      chk("A_out", {7'd0, a_ov, a_out}, {7'd0, exp_v});
    end
    chk("A_cnt", {8'd0, a_cnt}, {8'd0, cnt8});
    chk("B_hold_on_fall", {7'd0, b_ov, b_out}, {7'd0, b_prev});
    chk("C_hold_on_fall", {7'd0, c_ov, c_out}, {7'd0, c_prev});
  endtask

  initial begin
    model_reset();
    @(negedge clk); #1;
    chk("rst_A", {a_cnt, 7'd0, a_ov} | {8'd0, a_out}, 16'h0);
    chk("rst_B", {5'd0, b_cnt, b_ov, 7'd0} | {8'd0, b_out}, 16'h0);
    rst = 1'b0;

    // Legacy AND: F0, 00, F0
    step(MODE_AND, 8'hF0, 8'hFF, 1'b1, 1'b1);
    step(MODE_AND, 8'hF0, 8'hFF, 1'b1, 1'b1);
    step(MODE_AND, 8'hF0, 8'hFF, 1'b1, 1'b1);
    chk("and_q", {8'd0, b_out}, 16'h00F0);
    chk("and_cnt", {8'd0, a_cnt}, 16'd3);

    // LOAD then OR
    step(MODE_LOAD, 8'h5A, 8'h00, 1'b1, 1'b1);
    step(MODE_OR,   8'h0F, 8'h00, 1'b1, 1'b1);
    chk("or_q", {8'd0, b_out}, 16'h0005);
    chk("or_cnt", {8'd0, a_cnt}, 16'd5);

    // HOLD: valid but no change
    repeat (4) step(MODE_HOLD, 8'hAA, 8'h55, 1'b1, 1'b1);
    chk("hold_ov", {15'd0, a_ov}, 16'd1);
    chk("hold_cnt", {8'd0, a_cnt}, 16'd5);

    // in_valid without en is not an update
    repeat (3) step(MODE_LOAD, 8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("gate_ov", {15'd0, a_ov}, 16'd0);
    chk("gate_q", {8'd0, a_out}, 16'h0005);

    // Saturation of the 3-bit counter
    for (int i = 0; i < 10; i++)
      step(MODE_LOAD, (i % 2 == 0) ? 8'hFF : 8'h00, 8'h00, 1'b1, 1'b1);
    chk("sat_B", {13'd0, b_cnt}, 16'd7);
    chk("sat_A", {8'd0, a_cnt}, 16'd15);

    // Asynchronous reset between edges with q = FF and data in flight
    step(MODE_LOAD, 8'hFF, 8'h00, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_A", {a_cnt, 7'd0, a_ov} | {8'd0, a_out}, 16'h0);
    chk("arst_B", {5'd0, b_cnt, b_ov, 7'd0} | {8'd0, b_out}, 16'h0);
    chk("arst_C", {c_cnt, 7'd0, c_ov} | {8'd0, c_out}, 16'h0);
    rst = 1'b0;
    model_reset();

    // Single update after reset: A valid appears two edges later
    step(MODE_LOAD, 8'h3C, 8'h00, 1'b1, 1'b1);
    chk("lat_A0", {15'd0, a_ov}, 16'd0);
    step(MODE_HOLD, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_A1", {15'd0, a_ov}, 16'd0);
    step(MODE_HOLD, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat_A2", {7'd0, a_ov, a_out}, 16'h013C);
    repeat (4) step(MODE_HOLD, 8'h00, 8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
